// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
// The statistics counters are built only when PIPE_STAGE_STATS_EN is defined.
package pipe_pkg;

    // The occupancy output is wide enough for 0, 1 or 2 held entries.
    localparam int OCC_W = 2;

    // Default width of the statistics counters.
    localparam int DEF_CNT_W = 16;

    // Stage state, encoded as {skid_v, main_v}. 2'b10 (skid without main) is illegal.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'b00,
        PS_ONE   = 2'b01,
        PS_FULL  = 2'b11
    } ps_state_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter: counts up by one per inc cycle and sticks at all-ones.
// It is used for the statistics that exist only with PIPE_STAGE_STATS_EN.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    // Count qualifying cycles and stop at the maximum value instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_STAGE_STATS_EN to add the stall_cnt/flush_cnt statistics ports.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [OCC_W-1:0] occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_params
        $error("pipe_stage_reg: WIDTH and CNT_W must be at least 1");
    end

    logic             main_v_reg, main_v_next;
    logic             skid_v_reg, skid_v_next;
    logic [WIDTH-1:0] main_d_reg, main_d_next;
    logic [WIDTH-1:0] skid_d_reg, skid_d_next;
    logic             in_fire, out_fire;
    ps_state_e        state;

    // State is implied by the valid bits; decode it for the transition logic.
    assign state = ps_state_e'({skid_v_reg, main_v_reg});

    // in_ready depends on registered state plus the flush input only.
    assign in_ready  = !skid_v_reg && !flush;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_v_reg && out_ready;
    assign out_valid = main_v_reg;
    assign out_data  = main_d_reg;
    assign occupancy = OCC_W'(main_v_reg) + OCC_W'(skid_v_reg);

    // Next-state logic: data registers only change on the listed transitions.
    always_comb begin
        main_v_next = main_v_reg;
        skid_v_next = skid_v_reg;
        main_d_next = main_d_reg;
        skid_d_next = skid_d_reg;
        unique case (state)
            PS_EMPTY: begin
                if (in_fire) begin
                    main_v_next = 1'b1;
                    main_d_next = in_data;
                end
            end
            PS_ONE: begin
                if (in_fire && out_fire) begin
                    main_d_next = in_data;
                end else if (in_fire) begin
                    skid_v_next = 1'b1;
                    skid_d_next = in_data;
                end else if (out_fire) begin
                    main_v_next = 1'b0;
                end
            end
            PS_FULL: begin
                if (out_fire) begin
                    skid_v_next = 1'b0;
                    main_d_next = skid_d_reg;
                end
            end
            default: begin
                // Unreachable encoding: recover to empty.
                main_v_next = 1'b0;
                skid_v_next = 1'b0;
            end
        endcase
        // Flush overrides every transition; in_ready is already low so nothing is captured.
        if (flush) begin
            main_v_next = 1'b0;
            skid_v_next = 1'b0;
            if (CLEAR_DATA) begin
                main_d_next = '0;
                skid_d_next = '0;
            end else begin
                main_d_next = main_d_reg;
                skid_d_next = skid_d_reg;
            end
        end
    end

    // Stage registers; reset always clears data regardless of CLEAR_DATA.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_v_reg <= 1'b0;
            skid_v_reg <= 1'b0;
            main_d_reg <= '0;
            skid_d_reg <= '0;
        end else begin
            main_v_reg <= main_v_next;
            skid_v_reg <= skid_v_next;
            main_d_reg <= main_d_next;
            skid_d_reg <= skid_d_next;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = main_v_reg && !out_ready;
    assign flush_inc = flush && (main_v_reg || skid_v_reg);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .clear (1'b0),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .clear (1'b0),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a FIFO scoreboard of accepted payloads.
// Counter checks are compiled in only when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [OCC_W-1:0] occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] sb[$];

    pipe_stage_reg #(
        .WIDTH      (WIDTH),
        .CLEAR_DATA (1'b1),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven just after a falling edge; this samples 1 ns later,
    // updates the scoreboard and advances to the next falling edge.
    task automatic cycle();
        logic [WIDTH-1:0] exp;
        #1;
        if (out_valid === 1'b1 && out_ready) begin
            chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(exp));
                $display("pop  data=%0h expected=%0h", out_data, exp);
            end
        end
        if (in_valid && in_ready === 1'b1) begin
            sb.push_back(in_data);
            $display("push data=%0h", in_data);
        end
        if (flush) begin
            sb.delete();
            $display("flush");
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        flush = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);

        // 1. Fill to FULL, then reset asynchronously mid-cycle.
        in_valid = 1'b1; in_data = 8'h55; cycle();
        in_data = 8'h66; cycle();
        in_valid = 1'b0;
        #1;
        chk("t1_full_occ", 32'(occupancy), 32'd2);
        chk("t1_full_in_ready", 32'(in_ready), 32'd0);
        #1 rst = 1'b0;
        #1;
        chk("t1_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t1_rst_occ", 32'(occupancy), 32'd0);
        chk("t1_rst_out_data", 32'(out_data), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t1_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_STAGE_STATS_EN
        chk("t1_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("t1_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
        @(negedge clk);

        // 2. Streaming at full rate.
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h11; cycle();
        in_data = 8'h22;
        #1;
        chk("t2_occ_a", 32'(occupancy), 32'd1);
        chk("t2_in_ready_a", 32'(in_ready), 32'd1);
        cycle();
        in_data = 8'h33;
        #1;
        chk("t2_occ_b", 32'(occupancy), 32'd1);
        chk("t2_in_ready_b", 32'(in_ready), 32'd1);
        cycle();
        in_valid = 1'b0; cycle();
        #1;
        chk("t2_drained_occ", 32'(occupancy), 32'd0);
        @(negedge clk);

        // 3. Back-pressure: 0xA, 0xB fill the stage, 0xC waits upstream.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h0A; cycle();
        in_data = 8'h0B; cycle();
        in_data = 8'h0C;
        #1;
        chk("t3_occ_full", 32'(occupancy), 32'd2);
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        cycle();
        out_ready = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b0; cycle();
        #1;
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);
        chk("t3_occ_empty", 32'(occupancy), 32'd0);
`ifdef PIPE_STAGE_STATS_EN
        chk("t3_stall_cnt", 32'(stall_cnt), 32'd2);
`endif
        @(negedge clk);

        // 4. Flush while FULL with 0xD offered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h0E; cycle();
        in_data = 8'h0F; cycle();
        in_data = 8'h0D; flush = 1'b1;
        #1;
        chk("t4_in_ready_flush", 32'(in_ready), 32'd0);
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("t4_occ", 32'(occupancy), 32'd0);
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        chk("t4_out_data", 32'(out_data), 32'd0);
`ifdef PIPE_STAGE_STATS_EN
        chk("t4_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("t4_stall_cnt", 32'(stall_cnt), 32'd4);
`endif
        @(negedge clk);
        out_ready = 1'b1;
        cycle();
        cycle();
        #1;
        chk("t4_no_0d", 32'(out_valid), 32'd0);
        @(negedge clk);

        // 5. Flush while EMPTY leaves flush_cnt unchanged.
        flush = 1'b1; cycle();
        flush = 1'b0;
        #1;
        chk("t5_occ", 32'(occupancy), 32'd0);
`ifdef PIPE_STAGE_STATS_EN
        chk("t5_flush_cnt", 32'(flush_cnt), 32'd1);
`endif
        @(negedge clk);

        // 6. Long stall saturates stall_cnt at 15.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h77; cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        #1;
        chk("t6_held_data", 32'(out_data), 32'h77);
        chk("t6_held_occ", 32'(occupancy), 32'd1);
`ifdef PIPE_STAGE_STATS_EN
        chk("t6_stall_sat", 32'(stall_cnt), 32'd15);
`endif
        @(negedge clk);
        out_ready = 1'b1; cycle();
        #1;
        chk("t6_final_sb_empty", 32'(sb.size()), 32'd0);
        chk("t6_final_occ", 32'(occupancy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
